// File: rtl/serializer_merge_scheduler_pkg.sv
// Shared types and constants for the lane merge scheduler: FSM encoding,
// default widths and lane identifiers.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam int INDEX_W_DEF = 10;
  localparam int CNT_W_DEF   = 16;

  localparam int LANE_VARINT = 0;
  localparam int LANE_RAW    = 1;

endpackage

// File: rtl/serializer_merge_scheduler_if.sv
// Lane FIFO heads in, output FIFO write port out; the scheduler holds the master side.
interface serializer_merge_scheduler_if #(
  parameter int NUM_LANES = 2,
  parameter int INDEX_W   = 10
);

  // A byte moves on any clock edge where out_push is high. out_push is only
  // raised while out_full is low, and lane_pop mirrors out_push on the single
  // locked lane so the lane byte/index FIFOs and the output FIFO move together.
  logic [NUM_LANES-1:0]         lane_empty;
  logic [8*NUM_LANES-1:0]       lane_data;
  logic [INDEX_W*NUM_LANES-1:0] lane_index;
  logic [NUM_LANES-1:0]         lane_drained;
  logic [NUM_LANES-1:0]         lane_pop;
  logic                         out_full;
  logic                         out_push;
  logic [7:0]                   out_data;

  modport master (
    input  lane_empty, lane_data, lane_index, lane_drained, out_full,
    output lane_pop, out_push, out_data
  );

  modport slave (
    output lane_empty, lane_data, lane_index, lane_drained, out_full,
    input  lane_pop, out_push, out_data
  );

endinterface

// File: rtl/serializer_merge_scheduler_lane_min_select.sv
// Picks the valid lane holding the smallest field index; ties go to the lowest lane.
module lane_min_select #(
  parameter int  NUM_LANES = 2,
  parameter int  INDEX_W   = 10,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic [NUM_LANES-1:0]         valid,
  input  logic [INDEX_W*NUM_LANES-1:0] index,
  output logic [LANE_W-1:0]            lane,
  output logic                         found
);

  logic [INDEX_W-1:0] best;

  // Strict less-than keeps the earlier (lower) lane on equal indices.
  always_comb begin
    lane  = '0;
    found = 1'b0;
    best  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (valid[k] && (!found || (index[k*INDEX_W +: INDEX_W] < best))) begin
        found = 1'b1;
        lane  = LANE_W'(k);
        best  = index[k*INDEX_W +: INDEX_W];
      end
    end
  end

endmodule

// File: rtl/serializer_merge_scheduler.sv
// Merges per-lane encoded byte streams into one output FIFO in ascending
// field-index order, granting whole fields at a time.
module serializer_merge_scheduler
  import serializer_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int INDEX_W   = INDEX_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                        clock_clk,
  input  logic                        reset_reset,
  input  logic                        msg_start,
  serializer_merge_scheduler_if.master lanes,
  output logic                        busy,
  output logic                        msg_done,
  output logic [CNT_W-1:0]            byte_count,
  output sched_state_t                state_dbg
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  sched_state_t       state, state_nxt;
  logic [LANE_W-1:0]  lock_lane, grant_lane;
  logic [INDEX_W-1:0] lock_index, grant_index, head_index;
  logic [NUM_LANES-1:0] lane_valid;
  logic grant_found, all_ready, all_done;
  logic head_empty, head_drained, push, release_lock;

  assign lane_valid = ~lanes.lane_empty;
  // A lane that is empty but not drained may still produce an earlier field.
  assign all_ready  = &(lane_valid | lanes.lane_drained);
  assign all_done   = &(lanes.lane_empty & lanes.lane_drained);

  lane_min_select #(
    .NUM_LANES (NUM_LANES),
    .INDEX_W   (INDEX_W)
  ) u_min_select (
    .valid (lane_valid),
    .index (lanes.lane_index),
    .lane  (grant_lane),
    .found (grant_found)
  );

  assign grant_index  = lanes.lane_index[int'(grant_lane)*INDEX_W +: INDEX_W];
  assign head_index   = lanes.lane_index[int'(lock_lane)*INDEX_W +: INDEX_W];
  assign head_empty   = lanes.lane_empty[lock_lane];
  assign head_drained = lanes.lane_drained[lock_lane];

  assign release_lock = (!head_empty && (head_index != lock_index)) ||
                        (head_empty && head_drained);
  // Gated by reset so a mid-field reset cannot leak a final byte.
  assign push = (state == XFER) && !reset_reset && !head_empty &&
                (head_index == lock_index) && !lanes.out_full;

  always_ff @(posedge clock_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (msg_start) state_nxt = ARB;
      ARB: begin
        if (all_done)                      state_nxt = DONE;
        else if (all_ready && grant_found) state_nxt = XFER;
      end
      XFER:    if (release_lock) state_nxt = ARB;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lanes.lane_pop            = '0;
    lanes.lane_pop[lock_lane] = push;
    lanes.out_push            = push;
    lanes.out_data            = push ? lanes.lane_data[int'(lock_lane)*8 +: 8] : 8'h00;
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      lock_lane  <= '0;
      lock_index <= '0;
      byte_count <= '0;
    end else begin
      if ((state == ARB) && (state_nxt == XFER)) begin
        lock_lane  <= grant_lane;
        lock_index <= grant_index;
      end
      if ((state == IDLE) && msg_start)   byte_count <= '0;
      else if (push && (byte_count != '1)) byte_count <= byte_count + CNT_W'(1);
    end
  end

  assign busy      = (state != IDLE);
  assign msg_done  = (state == DONE);
  assign state_dbg = state;

endmodule
